// File: rtl/regfile_write_queue.sv
// Write-side front end for the 32x32 register file: in-order queue of
// pending writes, one-per-cycle drain port and pending-data lookup.
module regfile_write_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter bit DISCARD_R0 = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [ADDR_W-1:0]        inAddr,
  input  logic [DATA_W-1:0]        inData,
  input  logic                     drainEn,
  output logic                     writeEn,
  output logic [ADDR_W-1:0]        writeAddr,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        lookupAddr,
  output logic                     lookupHit,
  output logic [DATA_W-1:0]        lookupData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] qAddr [DEPTH];
  logic [DATA_W-1:0] qData [DEPTH];
  logic [PW-1:0]     headPtr;
  logic [PW-1:0]     tailPtr;

  logic isR0;
  logic doPush;
  logic doPop;

  assign inReady = (count < FULL);
  assign isR0    = DISCARD_R0 && (inAddr == '0);
  assign doPush  = inValid && inReady && !isR0;
  assign doPop   = drainEn && (count != '0);
  assign empty   = (count == '0) && !writeEn;

  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      writeEn   <= 1'b0;
      writeAddr <= '0;
      writeData <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + PW'(1);
      if (doPop)  headPtr <= headPtr + PW'(1);
      unique case (1'b1)
        (doPush && !doPop): count <= count + CW'(1);
        (doPop && !doPush): count <= count - CW'(1);
        default: ;
      endcase
      writeEn <= doPop;
      if (doPop) begin
        writeAddr <= qAddr[headPtr];
        writeData <= qData[headPtr];
      end
    end
  end

  // Storage needs no reset: validity is tracked by head/count only.
  always_ff @(posedge clk) begin
    if (doPush) begin
      qAddr[tailPtr] <= inAddr;
      qData[tailPtr] <= inData;
    end
  end

  logic              hit;
  logic [DATA_W-1:0] hitData;
  logic [PW-1:0]     idx;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    hit     = writeEn && (writeAddr == lookupAddr);
    hitData = hit ? writeData : '0;
    idx     = headPtr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = headPtr + PW'(k);
      if ((CW'(k) < count) && (qAddr[idx] == lookupAddr)) begin
        hit     = 1'b1;
        hitData = qData[idx];
      end
    end
    if (DISCARD_R0 && (lookupAddr == '0)) begin
      hit     = 1'b0;
      hitData = '0;
    end
  end

  assign lookupHit  = hit;
  assign lookupData = hitData;

endmodule
